// File: rtl/multicycle_subtractor.sv
// Multicycle subtractor: computes a - b one SLICE-bit chunk per clock, least-significant
// slice first, behind a ready/valid handshake on both the operand and result sides.
module multicycle_subtractor #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_d,
  output logic             io_out_borrow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_outD;
  logic             r_borrow;
  logic             r_outBorrow;
  logic [IDXW-1:0]  r_idx;

  logic             w_accept;
  logic             w_step;
  logic             w_lastSlice;
  logic [SLICE-1:0] w_aSlice;
  logic [SLICE-1:0] w_bSlice;
  logic [SLICE:0]   w_diff;
  logic [WIDTH-1:0] w_nextWork;

  assign w_accept    = (r_state == IDLE) && io_in_valid;
  assign w_step      = (r_state == RUN);
  assign w_lastSlice = (r_idx == LAST_IDX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    io_in_ready  = 1'b0;
    io_out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        io_in_ready = 1'b1;
        if (io_in_valid) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (w_lastSlice) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        io_out_valid = 1'b1;
        if (io_out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Mux out the operand slice addressed by the current index.
  always_comb begin
    w_aSlice = '0;
    w_bSlice = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_aSlice = r_a[k*SLICE +: SLICE];
        w_bSlice = r_b[k*SLICE +: SLICE];
      end
    end
  end

  // One extra bit on the subtraction so its MSB falls out as the slice borrow.
  assign w_diff = {1'b0, w_aSlice} - {1'b0, w_bSlice} - {{SLICE{1'b0}}, r_borrow};

  always_comb begin
    w_nextWork = r_work;
    for (int k = 0; k < NSLICE; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_nextWork[k*SLICE +: SLICE] = w_diff[SLICE-1:0];
      end
    end
  end

  // Partial results live in r_work so the visible result only changes when a run completes;
  // the index saturates at the last slice and is cleared by the next accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_work      <= '0;
      r_outD      <= '0;
      r_borrow    <= 1'b0;
      r_outBorrow <= 1'b0;
      r_idx       <= '0;
    end else if (w_accept) begin
      r_a      <= io_in_a;
      r_b      <= io_in_b;
      r_borrow <= 1'b0;
      r_idx    <= '0;
    end else if (w_step) begin
      r_work   <= w_nextWork;
      r_borrow <= w_diff[SLICE];
      if (w_lastSlice) begin
        r_outD      <= w_nextWork;
        r_outBorrow <= w_diff[SLICE];
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign io_out_d      = r_outD;
  assign io_out_borrow = r_outBorrow;

endmodule

// File: tb/tb_multicycle_subtractor.sv
// Self-checking bench for multicycle_subtractor: a scoreboard of expected differences
// is filled when operands are driven and drained when results appear.
module tb_multicycle_subtractor;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         io_in_valid;
  logic         io_in_ready;
  logic [W-1:0] io_in_a;
  logic [W-1:0] io_in_b;
  logic         io_out_valid;
  logic         io_out_ready;
  logic [W-1:0] io_out_d;
  logic         io_out_borrow;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] qD[$];
  logic         qB[$];

  multicycle_subtractor #(.WIDTH(32), .SLICE(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_a      (io_in_a),
    .io_in_b      (io_in_b),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_d     (io_out_d),
    .io_out_borrow(io_out_borrow)
  );

  always #5 clock = ~clock;

  // Reference model: plain wide subtraction, independent of slicing.
  task automatic pushExpected(input logic [W-1:0] a, input logic [W-1:0] b);
    qD.push_back(a - b);
    qB.push_back(a < b);
  endtask

  // Present one operand pair for a single edge; leaves time at #1 after that edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    io_in_a     = a;
    io_in_b     = b;
    io_in_valid = 1'b1;
    if (track) pushExpected(a, b);
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
  endtask

  // Count edges until io_out_valid, bounded so a dead DUT cannot hang the run.
  task automatic waitValid(output int n);
    n = 0;
    while (!io_out_valid && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    io_in_valid  = 1'b0;
    io_in_a      = '0;
    io_in_b      = '0;
    io_out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++; if (io_in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", io_in_ready); end
    total++; if (io_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", io_out_valid); end
    total++; if (io_out_d !== 32'h0) begin bad++; $display("[TB] FAIL reset_d got=%h want=00000000", io_out_d); end
    total++; if (io_out_borrow !== 1'b0) begin bad++; $display("[TB] FAIL reset_borrow got=%b want=0", io_out_borrow); end
    repeat (2) @(posedge clock);
    #1;
    total++; if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_held valid=%b ready=%b want valid=0 ready=1", io_out_valid, io_in_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] va[8];
    logic [W-1:0] vb[8];
    logic [W-1:0] ed;
    logic         eb;
    int n;
    va[0] = 32'h00000005; vb[0] = 32'h00000003;
    va[1] = 32'h00000100; vb[1] = 32'h00000001;
    va[2] = 32'h00000000; vb[2] = 32'h00000001;
    va[3] = 32'hDEADBEEF; vb[3] = 32'hDEADBEEF;
    va[4] = 32'hFFFFFFFF; vb[4] = 32'h00000000;
    va[5] = 32'h01000000; vb[5] = 32'h00FFFFFF;
    va[6] = $urandom;     vb[6] = $urandom;
    va[7] = $urandom;     vb[7] = $urandom;
    io_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (io_in_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_idle[%0d] got=%b want=1", i, io_in_ready); end
      applyStimulus(va[i], vb[i], 1'b1);
      waitValid(n);
      ed = qD.pop_front();
      eb = qB.pop_front();
      total++; if (n !== 4) begin bad++; $display("[TB] FAIL basic_latency[%0d] got=%0d want=4", i, n); end
      total++; if (io_out_d !== ed) begin bad++; $display("[TB] FAIL basic_d[%0d] got=%h want=%h", i, io_out_d, ed); end
      total++; if (io_out_borrow !== eb) begin bad++; $display("[TB] FAIL basic_borrow[%0d] got=%b want=%b", i, io_out_borrow, eb); end
      @(posedge clock);
      #1;
      total++; if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0) begin
        bad++; $display("[TB] FAIL basic_release[%0d] ready=%b valid=%b want ready=1 valid=0", i, io_in_ready, io_out_valid);
      end
    end
  endtask

  task automatic test_ignore_run();
    logic [W-1:0] ed;
    logic         eb;
    int n;
    io_out_ready = 1'b0;
    applyStimulus(32'h80000000, 32'h7FFFFFFF, 1'b1);
    io_in_valid = 1'b1;
    io_in_a     = $urandom;
    io_in_b     = $urandom;
    waitValid(n);
    io_in_valid = 1'b0;
    ed = qD.pop_front();
    eb = qB.pop_front();
    total++; if (io_out_d !== ed || io_out_borrow !== eb) begin
      bad++; $display("[TB] FAIL ignore_run d=%h borrow=%b want d=%h borrow=%b", io_out_d, io_out_borrow, ed, eb);
    end
    io_out_ready = 1'b1;
    @(posedge clock);
    #1;
    total++; if (io_in_ready !== 1'b1) begin bad++; $display("[TB] FAIL ignore_release got=%b want=1", io_in_ready); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ed;
    logic         eb;
    int n;
    io_out_ready = 1'b0;
    applyStimulus(32'h12345678, 32'h00000078, 1'b1);
    waitValid(n);
    ed = qD.pop_front();
    eb = qB.pop_front();
    total++; if (io_out_d !== ed || io_out_borrow !== eb) begin
      bad++; $display("[TB] FAIL bp_result d=%h borrow=%b want d=%h borrow=%b", io_out_d, io_out_borrow, ed, eb);
    end
    io_in_valid = 1'b1;
    io_in_a     = 32'hFFFFFFFF;
    io_in_b     = 32'h00000001;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      total++; if (io_out_d !== 32'h12345600) begin bad++; $display("[TB] FAIL bp_hold_d[%0d] got=%h want=12345600", c, io_out_d); end
      total++; if (io_out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_valid[%0d] got=%b want=1", c, io_out_valid); end
      total++; if (io_in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold_ready[%0d] got=%b want=0", c, io_in_ready); end
    end
    io_out_ready = 1'b1;
    pushExpected(32'hFFFFFFFF, 32'h00000001);
    @(posedge clock);
    #1;
    total++; if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL bp_release ready=%b valid=%b want ready=1 valid=0", io_in_ready, io_out_valid);
    end
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    waitValid(n);
    ed = qD.pop_front();
    eb = qB.pop_front();
    total++; if (n !== 4) begin bad++; $display("[TB] FAIL bp_next_latency got=%0d want=4", n); end
    total++; if (io_out_d !== ed || io_out_borrow !== eb) begin
      bad++; $display("[TB] FAIL bp_next d=%h borrow=%b want d=%h borrow=%b", io_out_d, io_out_borrow, ed, eb);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] ed;
    logic         eb;
    int n;
    io_out_ready = 1'b1;
    applyStimulus(32'hFFFF0000, 32'h00000001, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    total++; if (io_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_valid got=%b want=0", io_out_valid); end
    total++; if (io_in_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_ready got=%b want=1", io_in_ready); end
    total++; if (io_out_d !== 32'h0) begin bad++; $display("[TB] FAIL abort_d got=%h want=00000000", io_out_d); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(32'h0000000A, 32'h00000004, 1'b1);
    waitValid(n);
    ed = qD.pop_front();
    eb = qB.pop_front();
    total++; if (n !== 4) begin bad++; $display("[TB] FAIL abort_next_latency got=%0d want=4", n); end
    total++; if (io_out_d !== ed || io_out_borrow !== eb) begin
      bad++; $display("[TB] FAIL abort_next d=%h borrow=%b want d=%h borrow=%b", io_out_d, io_out_borrow, ed, eb);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_back_to_back();
    int  edgeCnt = 0;
    int  nAcc = 0;
    int  nRes = 0;
    int  accEdge[2];
    bit  accNow;
    logic [W-1:0] ed;
    logic         eb;
    accEdge[0] = 0;
    accEdge[1] = 0;
    io_out_ready = 1'b1;
    io_in_a      = 32'h0000F00D;
    io_in_b      = 32'h0000BEEF;
    io_in_valid  = 1'b1;
    pushExpected(io_in_a, io_in_b);
    while (edgeCnt < 40 && nRes < 2) begin
      accNow = io_in_ready && io_in_valid;
      if (io_out_valid) begin
        ed = qD.pop_front();
        eb = qB.pop_front();
        total++; if (io_out_d !== ed || io_out_borrow !== eb) begin
          bad++; $display("[TB] FAIL b2b_result[%0d] d=%h borrow=%b want d=%h borrow=%b", nRes, io_out_d, io_out_borrow, ed, eb);
        end
        nRes++;
      end
      @(posedge clock);
      #1;
      edgeCnt++;
      if (accNow && nAcc < 2) begin
        accEdge[nAcc] = edgeCnt;
        nAcc++;
        if (nAcc == 1) begin
          io_in_a = 32'h00001234;
          io_in_b = 32'h89ABCDEF;
          pushExpected(io_in_a, io_in_b);
        end else begin
          io_in_valid = 1'b0;
        end
      end
    end
    io_in_valid = 1'b0;
    total++; if (nRes !== 2) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=2", nRes); end
    total++; if (accEdge[1] - accEdge[0] !== 6) begin
      bad++; $display("[TB] FAIL b2b_spacing got=%0d want=6", accEdge[1] - accEdge[0]);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_run();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    total++; if (qD.size() !== 0) begin bad++; $display("[TB] FAIL scoreboard_leftover got=%0d want=0", qD.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_subtractor.md
MULTICYCLE_SUBTRACTOR -- requirements
Module: multicycle_subtractor

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, default 8: bits processed per cycle. NSLICE = WIDTH/SLICE.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 io_in_valid  input  1  operand pair valid.
REQ-006 io_in_ready  output  1  block can accept an operand pair.
REQ-007 io_in_a  input  WIDTH  minuend, unsigned.
REQ-008 io_in_b  input  WIDTH  subtrahend, unsigned.
REQ-009 io_out_valid  output  1  result valid.
REQ-010 io_out_ready  input  1  consumer accepts result.
REQ-011 io_out_d  output  WIDTH  difference a-b mod 2^WIDTH.
REQ-012 io_out_borrow  output  1  final borrow; 1 iff a < b unsigned.

Function
REQ-013 FSM states IDLE, RUN, DONE; io_in_ready SHALL be 1 only in IDLE; io_out_valid SHALL be 1 only in DONE.
REQ-014 Accept SHALL occur on a rising edge with io_in_valid=1 in IDLE: capture io_in_a/io_in_b, clear borrow register, clear slice index, go to RUN.
REQ-015 In RUN, each edge SHALL compute slice k: {borrow_out, d_k} = a[k] - b[k] - borrow_reg, at SLICE+1-bit width with the top bit as borrow; store d_k into result bits [k*SLICE +: SLICE]; borrow_reg <= borrow_out; k <= k+1.
REQ-016 Slice order SHALL be least-significant first; borrow-in of slice 0 SHALL be 0.
REQ-017 After the edge computing slice NSLICE-1, state SHALL be DONE; io_out_valid rises exactly NSLICE edges after the accept edge (4 for defaults).
REQ-018 In DONE, io_out_d and io_out_borrow SHALL hold stable until the handshake edge (io_out_ready=1); on that edge the FSM SHALL return to IDLE.
REQ-019 io_out_d and io_out_borrow SHALL hold their last values in IDLE and RUN and are meaningful only while io_out_valid=1.
REQ-020 io_in_valid outside IDLE SHALL be ignored; operand registers SHALL NOT change outside the accept edge.
REQ-021 No same-cycle result handoff and new accept: minimum spacing between accepts is NSLICE+2 edges with io_out_ready held at 1.
REQ-022 The slice index SHALL never exceed NSLICE-1; no wrap-around into slice 0 within one operation.
REQ-023 io_out_ready while not in DONE SHALL have no effect.

Reset
REQ-024 While reset=1, regardless of clock: state=IDLE, io_in_ready=1, io_out_valid=0, io_out_d=0, io_out_borrow=0, borrow_reg=0, slice index=0.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation; no result is ever presented for it.
REQ-026 First accept after reset deassertion SHALL be possible on the first rising edge with reset=0.

Verification
REQ-027 a=0x00000005, b=0x00000003, io_out_ready=1 -> io_out_valid high exactly 4 edges after accept, io_out_d=0x00000002, io_out_borrow=0.
REQ-028 a=0x00000100, b=0x00000001 -> io_out_d=0x000000FF, io_out_borrow=0 (borrow propagates from slice 0 into slice 1).
REQ-029 a=0x00000000, b=0x00000001 -> io_out_d=0xFFFFFFFF, io_out_borrow=1; a=b=0xDEADBEEF -> io_out_d=0x00000000, io_out_borrow=0.
REQ-030 Backpressure: after a=0x12345678, b=0x00000078, hold io_out_ready=0 for 3 cycles while driving io_in_valid=1 with new operands -> io_out_d=0x12345600 stable, io_in_ready=0, new operands not captured; io_out_ready=1 -> IDLE next edge, then new operands accepted.
REQ-031 Assert reset 2 edges into RUN -> io_out_valid=0, io_in_ready=1 immediately (asynchronous), io_out_d=0; after release, a=0x0000000A, b=0x00000004 -> io_out_d=0x00000006, io_out_borrow=0.
REQ-032 Back-to-back: 2 operations with io_in_valid and io_out_ready held at 1 -> accepts exactly NSLICE+2 edges apart, both results correct.
